// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver: state encoding and framing constants.
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 868;
   localparam int DATA_BITS            = 8;
   localparam int STOP_BITS            = 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_byte_rx_if.sv
// Byte-side bundle of the UART receiver; the receiver drives it, the loaders consume it.
interface uart_byte_rx_if;

   logic [7:0] rx_data;
   logic       rx_ready;
   logic       frame_err;
   logic       busy;

   modport master (output rx_data, rx_ready, frame_err, busy);
   modport slave  (input  rx_data, rx_ready, frame_err, busy);

endinterface

// File: rtl/uart_byte_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input pin, with a selectable reset level.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: synchronises rx, qualifies the start bit, samples each bit at its centre
// and reports good bytes, framing errors and break conditions as one-cycle pulses.
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           rx,
   uart_byte_rx_if.master rx_if
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

   if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
      $error("uart_byte_rx: CLKS_PER_BIT must be >= 4");
   end
   if (STOP_BITS != 1) begin : g_bad_stop_bits
      $error("uart_byte_rx: only one stop bit is supported");
   end

   logic             rx_s;
   rx_state_t        state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [2:0]       bit_idx, bit_idx_next;
   logic [7:0]       shift_reg, shift_next;
   logic [7:0]       rx_data_q, data_next;
   logic             ready_q, ready_next;
   logic             err_q, err_next;

   // Idle-high reset level keeps a reset release from looking like a start edge.
   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         rx_data_q <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         bit_idx   <= bit_idx_next;
         shift_reg <= shift_next;
         rx_data_q <= data_next;
         ready_q   <= ready_next;
         err_q     <= err_next;
      end
   end

   // Every sample point wraps the counter, so each bit is timed from the previous centre.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      bit_idx_next = bit_idx;
      shift_next   = shift_reg;
      data_next    = rx_data_q;
      ready_next   = 1'b0;
      err_next     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rx_s) begin
               state_next = ST_START;
               cnt_next   = '0;
            end
         end
         ST_START: begin
            if (cnt == HALF_LAST) begin
               cnt_next = '0;
               if (!rx_s) begin
                  state_next   = ST_DATA;
                  bit_idx_next = '0;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_next            = '0;
               shift_next[bit_idx] = rx_s;
               if (bit_idx == IDX_LAST) begin
                  state_next = ST_STOP;
               end else begin
                  bit_idx_next = bit_idx + 1'b1;
               end
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         ST_STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_next = '0;
               if (rx_s) begin
                  data_next  = shift_reg;
                  ready_next = 1'b1;
                  state_next = ST_IDLE;
               end else begin
                  err_next   = 1'b1;
                  state_next = ST_BREAK;
               end
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         ST_BREAK: begin
            if (rx_s) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign rx_if.rx_data   = rx_data_q;
   assign rx_if.rx_ready  = ready_q;
   assign rx_if.frame_err = err_q;
   assign rx_if.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: table-driven frames, corner-case sequences and a
// random byte stream checked by a scoreboard of expected bytes and their start-edge times.
module tb_uart_byte_rx;

   localparam int CPB      = 16;
   localparam int PERIOD   = 10;
   localparam int LAT_MIN  = (19 * CPB) / 2 + 2;
   localparam int LAT_MAX  = (19 * CPB) / 2 + 4;
   localparam int N_RANDOM = 200;
   localparam int N_VECS   = 6;

   typedef struct {
      logic [7:0] data;
      logic       stop_bit;
      int         hold_low;
      int         idle_bits;
      int         exp_ready;
      int         exp_err;
      logic [7:0] exp_data;
      logic       exp_busy;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rx    = 1'b1;

   uart_byte_rx_if rx_if ();

   uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rx),
      .rx_if (rx_if)
   );

   always #(PERIOD / 2) clk = ~clk;

   int checks      = 0;
   int errors      = 0;
   int ready_count = 0;
   int err_count   = 0;

   logic [7:0] exp_q[$];
   time        fall_q[$];

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: every good pulse must match the oldest expected byte, arrive inside the
   // latency window, and the byte outputs must otherwise hold still.
   logic       prev_ready = 1'b0;
   logic       prev_err   = 1'b0;
   logic       prev_rst   = 1'b0;
   logic [7:0] prev_data  = 8'h00;
   always @(negedge clk) begin
      logic [7:0] exp_byte;
      time        fall_t;
      int         lat;
      if (rst_n && prev_rst) begin
         if (rx_if.rx_ready) begin
            ready_count++;
            check_output("ready_with_err", rx_if.frame_err, 0);
            check_output("pulse_after_pulse", prev_ready | prev_err, 0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_ready: got data 0x%0h, expected no pulse", rx_if.rx_data);
            end else begin
               exp_byte = exp_q.pop_front();
               fall_t   = fall_q.pop_front();
               check_output("scoreboard_data", rx_if.rx_data, exp_byte);
               lat = int'(($time - fall_t) / PERIOD);
               checks++;
               if (lat < LAT_MIN || lat > LAT_MAX) begin
                  errors++;
                  $display("[TB] FAIL latency: got %0d cycles, expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
               end
            end
         end else begin
            check_output("rx_data_hold", rx_if.rx_data, prev_data);
         end
         if (rx_if.frame_err) begin
            err_count++;
            check_output("err_after_pulse", prev_ready | prev_err, 0);
         end
      end
      prev_ready = rx_if.rx_ready;
      prev_err   = rx_if.frame_err;
      prev_data  = rx_if.rx_data;
      prev_rst   = rst_n;
   end

   // All line-driving tasks start and end on a falling clock edge.
   task automatic send_bit(input logic b);
      rx = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit expect_byte);
      if (expect_byte) begin
         exp_q.push_back(d);
         fall_q.push_back($time);
      end
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop_bit);
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * CPB) @(negedge clk);
   endtask

   task automatic apply_stimulus(input vec_t v, input int idx);
      int r0, e0;
      r0 = ready_count;
      e0 = err_count;
      idle_bits(v.idle_bits);
      send_frame(v.data, v.stop_bit, v.stop_bit);
      repeat (v.hold_low) @(negedge clk);
      check_output($sformatf("vec%0d_ready_count", idx), ready_count - r0, v.exp_ready);
      check_output($sformatf("vec%0d_err_count", idx), err_count - e0, v.exp_err);
      check_output($sformatf("vec%0d_rx_data", idx), rx_if.rx_data, v.exp_data);
      check_output($sformatf("vec%0d_busy", idx), rx_if.busy, v.exp_busy);
      rx = 1'b1;
   endtask

   task automatic wait_busy(input logic level, input int max_cycles, input string name);
      int n = 0;
      while (rx_if.busy !== level && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check_output(name, rx_if.busy, level);
   endtask

   initial begin
      #(PERIOD * 90000);
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   vec_t vecs[N_VECS];

   initial begin
      int r0, e0, gap;
      logic [7:0] d;

      vecs[0] = '{8'h66, 1'b1, 0,   2, 1, 0, 8'h66, 1'b0};
      vecs[1] = '{8'h66, 1'b1, 0,   3, 1, 0, 8'h66, 1'b0};
      vecs[2] = '{8'hBB, 1'b1, 0,   0, 1, 0, 8'hBB, 1'b0};
      vecs[3] = '{8'h12, 1'b1, 0,   2, 1, 0, 8'h12, 1'b0};
      vecs[4] = '{8'hA5, 1'b0, 100, 1, 0, 1, 8'h12, 1'b1};
      vecs[5] = '{8'h3C, 1'b1, 0,   2, 1, 0, 8'h3C, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      check_output("reset_rx_data", rx_if.rx_data, 8'h00);
      check_output("reset_rx_ready", rx_if.rx_ready, 0);
      check_output("reset_frame_err", rx_if.frame_err, 0);
      check_output("reset_busy", rx_if.busy, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < N_VECS; i++) apply_stimulus(vecs[i], i);

      // Short low glitch must be rejected at the start-bit centre.
      idle_bits(2);
      r0 = ready_count;
      e0 = err_count;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      wait_busy(1'b1, 20, "glitch_busy_rise");
      wait_busy(1'b0, 4 * CPB, "glitch_busy_fall");
      idle_bits(2);
      check_output("glitch_ready_count", ready_count - r0, 0);
      check_output("glitch_err_count", err_count - e0, 0);
      send_frame(8'h3C, 1'b1, 1'b1);
      check_output("after_glitch_rx_data", rx_if.rx_data, 8'h3C);

      // Reset in the middle of a byte discards it.
      idle_bits(2);
      r0 = ready_count;
      fork
         send_frame(8'hFF, 1'b1, 1'b0);
         begin
            repeat (5 * CPB) @(negedge clk);
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            check_output("midreset_rx_data", rx_if.rx_data, 8'h00);
            check_output("midreset_rx_ready", rx_if.rx_ready, 0);
            check_output("midreset_frame_err", rx_if.frame_err, 0);
            check_output("midreset_busy", rx_if.busy, 0);
            @(posedge clk);
            #2 rst_n = 1'b1;
         end
      join
      idle_bits(2);
      check_output("midreset_no_ready", ready_count - r0, 0);
      send_frame(8'h81, 1'b1, 1'b1);
      idle_bits(1);
      check_output("after_reset_rx_data", rx_if.rx_data, 8'h81);
      check_output("after_reset_ready_count", ready_count - r0, 1);

      // Random stream ending with the end-marker pair sent back-to-back.
      r0 = ready_count;
      for (int i = 0; i < N_RANDOM; i++) begin
         d   = 8'($urandom);
         gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         idle_bits(gap);
         send_frame(d, 1'b1, 1'b1);
      end
      send_frame(8'h66, 1'b1, 1'b1);
      send_frame(8'hBB, 1'b1, 1'b1);
      idle_bits(2);
      check_output("stream_ready_count", ready_count - r0, N_RANDOM + 2);
      check_output("stream_pending", exp_q.size(), 0);
      check_output("stream_last_data", rx_if.rx_data, 8'hBB);
      check_output("total_frame_err", err_count, 1);
      check_output("final_busy", rx_if.busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
